// File: rtl/sl_preceptron_pkg.sv
// Shared types and defaults for the sl_preceptron sequencer slice.
// Contents:
//   state_t          - sequencer FSM states
//   DEF_*            - default geometry of the perceptron job
//   sl_sum_width()   - accumulator width needed for a full dot product
package sl_preceptron_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    VERIFY_W,
    STREAM_D,
    WAIT_RES,
    REPORT
  } state_t;

  localparam int DEF_DATA_IN_LANES  = 4;
  localparam int DEF_DATA_IN_WIDTH  = 8;
  localparam int DEF_WEIGHTS_WIDTH  = 8;
  localparam int DEF_MEM_ADDR_WIDTH = 16;
  localparam int DEF_VECTOR_LENGTH  = 128;
  localparam int DEF_RESULT_LATENCY = 4;

  // Product width plus enough headroom for VECTOR_LENGTH accumulations.
  function automatic int sl_sum_width(input int data_w, input int weights_w, input int vec_len);
    return data_w + weights_w + $clog2(vec_len);
  endfunction

endpackage

// File: rtl/sl_preceptron_lane_packer.sv
// Byte-to-lane packer: collects LANES consecutive bytes (lane 0 first, in the
// LSBs) and emits the packed word with a one-cycle valid strobe in the cycle
// after the last lane was accepted. out_data holds between strobes.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   in_valid   - one byte accepted this cycle
//   in_data    - the accepted byte
//   out_valid  - packed word strobe (one cycle)
//   out_data   - packed word, lane0 in LSBs
module sl_preceptron_lane_packer
  import sl_preceptron_pkg::*;
#(
  parameter int LANES  = DEF_DATA_IN_LANES,
  parameter int WIDTH  = DEF_DATA_IN_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data
);

  localparam int LC_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LC_W-1:0]        lane_cnt;
  logic [LANES*WIDTH-1:0] word_acc;
  logic [LANES*WIDTH-1:0] word_nxt;

  always_comb begin
    word_nxt = word_acc;
    word_nxt[lane_cnt*WIDTH +: WIDTH] = in_data;
  end

  // Partial word: pure data, never needs clearing since every lane is
  // overwritten before a word is emitted.
  always_ff @(posedge clk) begin
    if (in_valid) word_acc <= word_nxt;
  end

  // ---- stage boundary: packed word out ----
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        if (lane_cnt == LC_W'(LANES - 1)) begin
          lane_cnt  <= '0;
          out_valid <= 1'b1;
          out_data  <= word_nxt;
        end else begin
          lane_cnt <= lane_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sl_preceptron_seq.sv
// Hardware initiator for sl_preceptron_top. One job = threshold + a byte
// stream of VECTOR_LENGTH weights followed by VECTOR_LENGTH samples. Weights
// are written to the perceptron weight memory, samples are streamed as
// DATA_IN_LANES-wide beats, and after RESULT_LATENCY cycles the perceptron
// status is captured and offered on a result handshake.
// Optional build macro: SL_PRECEPTRON_SEQ_READBACK_EN adds a VERIFY_W pass
// that reads the weights back and flags any mismatch on res_err.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   start, job_threshold, busy - job control
//   s_valid, s_ready, s_data   - byte-stream input
//   mem_wen, mem_ren, mem_addr, mem_wdata, mem_rdata - weight memory port
//   data_valid, data_in        - data beats to the perceptron
//   cfg_ai_threshold           - threshold held for the whole job
//   status_ai_sum, status_ai_comparator - perceptron result
//   res_valid, res_ready, res_sum, res_comp, res_err - result handshake
module sl_preceptron_seq
  import sl_preceptron_pkg::*;
#(
  parameter int DATA_IN_LANES  = DEF_DATA_IN_LANES,
  parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
  parameter int WEIGHTS_WIDTH  = DEF_WEIGHTS_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int VECTOR_LENGTH  = DEF_VECTOR_LENGTH,
  parameter int SUM_WIDTH      = sl_sum_width(DATA_IN_WIDTH, WEIGHTS_WIDTH, VECTOR_LENGTH),
  parameter int RESULT_LATENCY = DEF_RESULT_LATENCY
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [SUM_WIDTH-1:0]                  job_threshold,
  output logic                                  busy,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [DATA_IN_WIDTH-1:0]              s_data,
  output logic                                  mem_wen,
  output logic                                  mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0]             mem_addr,
  output logic [WEIGHTS_WIDTH-1:0]              mem_wdata,
  input  logic [WEIGHTS_WIDTH-1:0]              mem_rdata,
  output logic                                  data_valid,
  output logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] data_in,
  output logic [SUM_WIDTH-1:0]                  cfg_ai_threshold,
  input  logic [SUM_WIDTH-1:0]                  status_ai_sum,
  input  logic                                  status_ai_comparator,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [SUM_WIDTH-1:0]                  res_sum,
  output logic                                  res_comp,
  output logic                                  res_err
);

  localparam int CNT_W = $clog2(VECTOR_LENGTH + 1);
  localparam int IDX_W = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
  localparam int LAT_W = $clog2(RESULT_LATENCY + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bcnt;      // bytes accepted in the current phase
  logic [LAT_W-1:0] lat_cnt;   // cycles since the last data beat
  logic             xfer;
  logic             w_last;
  logic             d_done;

  assign xfer   = s_valid && s_ready;
  assign w_last = (bcnt == CNT_W'(VECTOR_LENGTH - 1));
  assign d_done = (bcnt == CNT_W'(VECTOR_LENGTH));

`ifdef SL_PRECEPTRON_SEQ_READBACK_EN
  logic [WEIGHTS_WIDTH-1:0] shadow [VECTOR_LENGTH];
  logic [CNT_W-1:0]         rcnt;
  logic                     ren_q;
  logic                     cmp_pend;
  logic [IDX_W-1:0]         cmp_idx;
  logic                     err_q;
  logic                     rb_done;

  assign rb_done = cmp_pend && (cmp_idx == IDX_W'(VECTOR_LENGTH - 1));
  assign mem_ren = ren_q;
  assign res_err = err_q;

  always_ff @(posedge clk) begin
    if (state == LOAD_W && xfer) shadow[bcnt[IDX_W-1:0]] <= s_data;
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign mem_ren = 1'b0;
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD_W;
      end
      LOAD_W: begin
        s_ready = 1'b1;
`ifdef SL_PRECEPTRON_SEQ_READBACK_EN
        if (s_valid && w_last) state_nxt = VERIFY_W;
`else
        if (s_valid && w_last) state_nxt = STREAM_D;
`endif
      end
`ifdef SL_PRECEPTRON_SEQ_READBACK_EN
      VERIFY_W: begin
        if (rb_done) state_nxt = STREAM_D;
      end
`endif
      STREAM_D: begin
        s_ready = !d_done;
        // Stay here until the final beat has actually been strobed out.
        if (data_valid && d_done) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (lat_cnt == LAT_W'(RESULT_LATENCY)) state_nxt = REPORT;
      end
      REPORT: begin
        if (res_valid && res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage boundary: registered memory port, beat counters, result ----
  always_ff @(posedge clk) begin
    if (rst) begin
      busy             <= 1'b0;
      cfg_ai_threshold <= '0;
      mem_wen          <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      bcnt             <= '0;
      lat_cnt          <= '0;
      res_valid        <= 1'b0;
      res_sum          <= '0;
      res_comp         <= 1'b0;
`ifdef SL_PRECEPTRON_SEQ_READBACK_EN
      rcnt             <= '0;
      ren_q            <= 1'b0;
      cmp_pend         <= 1'b0;
      cmp_idx          <= '0;
      err_q            <= 1'b0;
`endif
    end else begin
      mem_wen <= 1'b0;
`ifdef SL_PRECEPTRON_SEQ_READBACK_EN
      ren_q    <= 1'b0;
      cmp_pend <= ren_q;
      cmp_idx  <= mem_addr[IDX_W-1:0];
      if (cmp_pend && (mem_rdata != shadow[cmp_idx])) err_q <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            cfg_ai_threshold <= job_threshold;
            busy             <= 1'b1;
            bcnt             <= '0;
            lat_cnt          <= '0;
`ifdef SL_PRECEPTRON_SEQ_READBACK_EN
            rcnt             <= '0;
            err_q            <= 1'b0;
`endif
          end
        end
        LOAD_W: begin
          if (xfer) begin
            mem_wen   <= 1'b1;
            mem_addr  <= MEM_ADDR_WIDTH'(bcnt);
            mem_wdata <= s_data;
            bcnt      <= w_last ? '0 : bcnt + 1'b1;
          end
        end
`ifdef SL_PRECEPTRON_SEQ_READBACK_EN
        VERIFY_W: begin
          // First read lands one cycle after the last write strobe, so the
          // two memory strobes never overlap.
          if (rcnt != CNT_W'(VECTOR_LENGTH)) begin
            ren_q    <= 1'b1;
            mem_addr <= MEM_ADDR_WIDTH'(rcnt);
            rcnt     <= rcnt + 1'b1;
          end
        end
`endif
        STREAM_D: begin
          if (xfer) bcnt <= bcnt + 1'b1;
          if (data_valid && d_done) lat_cnt <= LAT_W'(1);
        end
        WAIT_RES: begin
          if (lat_cnt == LAT_W'(RESULT_LATENCY)) begin
            res_sum   <= status_ai_sum;
            res_comp  <= status_ai_comparator;
            res_valid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  sl_preceptron_lane_packer #(
    .LANES (DATA_IN_LANES),
    .WIDTH (DATA_IN_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (xfer && (state == STREAM_D)),
    .in_data   (s_data),
    .out_valid (data_valid),
    .out_data  (data_in)
  );

endmodule

// File: tb/tb_sl_preceptron_seq.sv
module tb_sl_preceptron_seq;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int WW    = 8;
  localparam int AW    = 16;
  localparam int VL    = 128;
  localparam int SW    = 23;
  localparam int LAT   = 4;
  localparam int IW    = $clog2(VL);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [SW-1:0]       job_threshold = '0;
  logic                busy;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [DW-1:0]       s_data = '0;
  logic                mem_wen, mem_ren;
  logic [AW-1:0]       mem_addr;
  logic [WW-1:0]       mem_wdata;
  logic [WW-1:0]       mem_rdata = '0;
  logic                data_valid;
  logic [LANES*DW-1:0] data_in;
  logic [SW-1:0]       cfg_ai_threshold;
  logic [SW-1:0]       status_ai_sum;
  logic                status_ai_comparator;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [SW-1:0]       res_sum;
  logic                res_comp, res_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sl_preceptron_seq dut (
    .clk(clk), .rst(rst), .start(start), .job_threshold(job_threshold), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .data_valid(data_valid), .data_in(data_in),
    .cfg_ai_threshold(cfg_ai_threshold), .status_ai_sum(status_ai_sum),
    .status_ai_comparator(status_ai_comparator), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_comp(res_comp), .res_err(res_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Weight memory + perceptron model. status is only correct exactly
  // LAT cycles after the last data beat, wrong (inverted) otherwise.
  logic [WW-1:0] wmem [VL];
  logic [SW-1:0] acc = '0;
  logic [SW-1:0] sum_final = '0;
  int            beat = 0;
  int            kcnt = 0;
  logic          corrupt = 1'b0;

  assign status_ai_sum        = (kcnt == LAT) ? sum_final : ~sum_final;
  assign status_ai_comparator = (kcnt == LAT) ? (sum_final >= cfg_ai_threshold)
                                              : !(sum_final >= cfg_ai_threshold);

  always @(posedge clk) begin : model
    logic [SW-1:0] s;
    if (mem_wen) wmem[mem_addr[IW-1:0]] <= mem_wdata;
    if (mem_ren) mem_rdata <= wmem[mem_addr[IW-1:0]] ^ ((corrupt && mem_addr == 5) ? 8'h01 : 8'h00);
    if (rst) begin
      beat <= 0;
      kcnt <= 0;
    end else if (data_valid) begin
      s = (beat == 0) ? '0 : acc;
      for (int i = 0; i < LANES; i++) s = s + data_in[i*DW +: DW] * wmem[beat*LANES + i];
      acc <= s;
      if (beat == VL/LANES - 1) begin
        beat      <= 0;
        sum_final <= s;
        kcnt      <= 1;
      end else begin
        beat <= beat + 1;
      end
    end else if (kcnt != 0 && kcnt < 1000) begin
      kcnt <= kcnt + 1;
    end
  end

  // Per-cycle monitor: every accepted byte must produce exactly the expected
  // write strobe or packed beat one cycle later, and nothing on gap cycles.
  int            byte_idx = 0;
  int            mon_bad = 0;
  int            n_wen = 0;
  int            n_dv = 0;
  logic [DW-1:0] pk [LANES];

  always @(posedge clk) begin : mon
    logic                x;
    logic [DW-1:0]       d;
    int                  idx;
    logic                exp_wen, exp_dv;
    logic [LANES*DW-1:0] w;
    x   = s_valid && s_ready;
    d   = s_data;
    idx = byte_idx;
    if (x) byte_idx = byte_idx + 1;
    #1;
    if (!rst) begin
      exp_wen = x && (idx < VL);
      exp_dv  = 1'b0;
      if (x && idx >= VL) begin
        pk[(idx - VL) % LANES] = d;
        exp_dv = (((idx - VL) % LANES) == LANES - 1);
      end
      if (mem_wen !== exp_wen) mon_bad++;
      if (exp_wen && (mem_addr !== AW'(idx) || mem_wdata !== d)) mon_bad++;
      if (mem_wen === 1'b1) n_wen++;
      if (data_valid !== exp_dv) mon_bad++;
      if (data_valid === 1'b1) n_dv++;
      if (exp_dv) begin
        for (int i = 0; i < LANES; i++) w[i*DW +: DW] = pk[i];
        if (data_in !== w) mon_bad++;
      end
      if (mem_wen === 1'b1 && mem_ren === 1'b1) mon_bad++;
`ifndef SL_PRECEPTRON_SEQ_READBACK_EN
      if (mem_ren !== 1'b0) mon_bad++;
`endif
    end
  end

  typedef struct {
    logic [SW-1:0] thr;
    int            wkind;   // 0 constant, 1 index, 2 index%LANES
    int            wval;
    int            dkind;
    int            dval;
    bit            gap;
    bit            hold;
    logic [SW-1:0] exp_sum;
    bit            exp_comp;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [7:0] pat(input int kind, input int val, input int k);
    case (kind)
      0:       return 8'(val);
      1:       return 8'(k);
      default: return 8'(k % LANES);
    endcase
  endfunction

  task automatic start_job(input logic [SW-1:0] thr);
    @(negedge clk);
    byte_idx = 0; n_wen = 0; n_dv = 0; mon_bad = 0;
    job_threshold = thr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("cfg_threshold_latched", cfg_ai_threshold, thr);
  endtask

  task automatic feed(input int v, input int nbytes);
    int sent = 0;
    int cyc = 0;
    while (sent < nbytes && cyc < 4000) begin
      s_valid = tbl[v].gap ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = (sent < VL) ? pat(tbl[v].wkind, tbl[v].wval, sent)
                            : pat(tbl[v].dkind, tbl[v].dval, sent - VL);
      if (s_valid && s_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    if (sent < nbytes) chk("feed_timeout", sent, nbytes);
    // A byte of the next job waits upstream; it must not be consumed.
    s_valid = 1'b1;
    s_data  = 8'hA5;
  endtask

  task automatic finish_job(input int v, input bit exp_err);
    int cyc = 0;
    int held_bad = 0;
    int hold_bad = 0;
    while (res_valid !== 1'b1 && cyc < 600) begin
      if (s_ready !== 1'b0) held_bad++;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d_res_valid", v), res_valid, 1);
    chk($sformatf("v%0d_leftover_byte_held", v), held_bad, 0);
    chk($sformatf("v%0d_res_sum", v), res_sum, tbl[v].exp_sum);
    chk($sformatf("v%0d_res_comp", v), res_comp, tbl[v].exp_comp);
    chk($sformatf("v%0d_res_err", v), res_err, exp_err);
    chk($sformatf("v%0d_cfg_threshold", v), cfg_ai_threshold, tbl[v].thr);
    chk($sformatf("v%0d_busy_report", v), busy, 1);
    chk($sformatf("v%0d_wen_count", v), n_wen, VL);
    chk($sformatf("v%0d_beat_count", v), n_dv, VL/LANES);
    chk($sformatf("v%0d_cycle_monitor", v), mon_bad, 0);
    if (tbl[v].hold) begin
      for (int i = 0; i < 20; i++) begin
        start = 1'b1;
        job_threshold = ~tbl[v].thr;
        @(negedge clk);
        if (res_valid !== 1'b1 || res_sum !== tbl[v].exp_sum || res_comp !== tbl[v].exp_comp ||
            busy !== 1'b1 || cfg_ai_threshold !== tbl[v].thr || s_ready !== 1'b0) hold_bad++;
      end
      chk($sformatf("v%0d_hold_stable", v), hold_bad, 0);
    end
    // start in the accept cycle must be ignored
    res_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    chk($sformatf("v%0d_res_valid_drop", v), res_valid, 0);
    chk($sformatf("v%0d_busy_drop", v), busy, 0);
    @(negedge clk);
    chk($sformatf("v%0d_idle_after_accept", v), s_ready, 0);
    chk($sformatf("v%0d_busy_idle", v), busy, 0);
  endtask

  task automatic run_vec(input int v, input bit exp_err);
    start_job(tbl[v].thr);
    feed(v, 2*VL);
    finish_job(v, exp_err);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_mem_wen"}, mem_wen, 0);
    chk({tag, "_mem_ren"}, mem_ren, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_data_valid"}, data_valid, 0);
    chk({tag, "_data_in"}, data_in, 0);
    chk({tag, "_cfg_threshold"}, cfg_ai_threshold, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_sum"}, res_sum, 0);
    chk({tag, "_res_comp"}, res_comp, 0);
    chk({tag, "_res_err"}, res_err, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    //          thr      wk wv  dk dv  gap hold exp_sum  exp_comp
    tbl[0] = '{23'd100,  0, 1,  0, 1,  0,  0,  23'd128,     1};  // all ones
    tbl[1] = '{23'd200,  0, 1,  0, 1,  1,  0,  23'd128,     0};  // same, gapped
    tbl[2] = '{23'd0,    0, 0,  0, 255,0,  0,  23'd0,       1};  // zero weights, 0>=0
    tbl[3] = '{23'd8323200, 0, 255, 0, 255, 0, 1, 23'd8323200, 1}; // max product, thr==sum
    tbl[4] = '{23'd8129, 1, 0,  0, 1,  0,  0,  23'd8128,    0};  // w=k, sum 0..127
    tbl[5] = '{23'd384,  0, 2,  2, 0,  0,  0,  23'd384,     1};  // d=lane idx
    tbl[6] = '{23'd8323201, 0, 255, 0, 255, 1, 0, 23'd8323200, 0}; // gapped max, thr above

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset");

    // back-to-back table jobs
    for (int v = 0; v < 7; v++) run_vec(v, 1'b0);

    // reset during STREAM_D at beat 10
    start_job(tbl[0].thr);
    feed(0, VL + 10*LANES);
    chk("partial_beats", n_dv, 10);
    chk("partial_monitor", mon_bad, 0);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("midjob_rst");
    run_vec(4, 1'b0);

`ifdef SL_PRECEPTRON_SEQ_READBACK_EN
    corrupt = 1'b1;
    run_vec(0, 1'b1);
    corrupt = 1'b0;
    run_vec(0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
